// File: rtl/div_pkg.sv
// Shared constants, state encoding and result payload for the sequential divider tile.
package div_pkg;
  localparam int unsigned DW = 8;
  localparam int unsigned VW = 4;
  localparam int unsigned CW = 3;
  localparam int unsigned PW = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [DW-1:0] DIV0_Q = 8'hFF;
  localparam logic [VW-1:0] DIV0_R = 4'hF;
  localparam logic [PW-1:0] UIO_OE = 8'b1100_0000;

  typedef struct packed {
    logic          div0;
    logic [VW-1:0] rem;
    logic [DW-1:0] quo;
  } div_res_t;
endpackage

// File: rtl/tt_um_seq_divider_structural_if.sv
// Tiny Tapeout user pin bundle; master drives the inputs, slave is the tile.
interface tt_um_seq_divider_structural_if;
  import div_pkg::*;

  logic [PW-1:0] ui_in;
  logic [PW-1:0] uio_in;
  logic [PW-1:0] uio_out;
  logic [PW-1:0] uio_oe;
  logic [PW-1:0] uo_out;

  modport master (output ui_in, uio_in, input uio_out, uio_oe, uo_out);
  modport slave  (input ui_in, uio_in, output uio_out, uio_oe, uo_out);
endinterface

// File: rtl/div_step.sv
// One restoring division step: shift in the next dividend bit, subtract if it fits.
module div_step
  import div_pkg::*;
(
  input  logic [VW:0]   rem,
  input  logic [DW-1:0] dq,
  input  logic [VW-1:0] d,
  output logic [VW:0]   rem_n,
  output logic [DW-1:0] dq_n
);
  logic [VW:0] rs;
  logic [VW:0] dz;
  logic        qb;
  logic        unused_msb;

  // rem never exceeds d-1, so its top bit carries no information into the shift
  assign unused_msb = rem[VW];

  always_comb begin
    rs    = {rem[VW-1:0], dq[DW-1]};
    dz    = {1'b0, d};
    qb    = (rs >= dz);
    rem_n = qb ? (rs - dz) : rs;
    dq_n  = {dq[DW-2:0], qb};
  end
endmodule

// File: rtl/tt_um_seq_divider_structural.sv
// Sequential 8/4 restoring divider tile: start/sel/divisor on uio_in, done/busy on uio_out.
module tt_um_seq_divider_structural (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  tt_um_seq_divider_structural_if.slave bus
);
  import div_pkg::*;

  logic [1:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DW-1:0] dq, dq_n;
  logic [VW:0]   rem, rem_n;
  logic [VW-1:0] d, d_n;
  div_res_t      res, res_n;
  logic          done, done_n;
  logic          busy, busy_n;

  logic [VW:0]   step_rem;
  logic [DW-1:0] step_dq;

  logic          start;
  logic          sel;
  logic [VW-1:0] div_in;

  assign start  = bus.uio_in[4];
  assign sel    = bus.uio_in[5];
  assign div_in = bus.uio_in[VW-1:0];

  wire _unused = &{1'b0, ena, bus.uio_in[7:6]};

  div_step u_step (
    .rem   (rem),
    .dq    (dq),
    .d     (d),
    .rem_n (step_rem),
    .dq_n  (step_dq)
  );

  // Next-state and datapath update
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dq_n    = dq;
    rem_n   = rem;
    d_n     = d;
    res_n   = res;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (div_in == '0) begin
            state_n = ST_DONE;
            res_n   = '{div0: 1'b1, rem: DIV0_R, quo: DIV0_Q};
          end else begin
            state_n    = ST_RUN;
            dq_n       = bus.ui_in;
            d_n        = div_in;
            rem_n      = '0;
            cnt_n      = CW'(DW - 1);
            res_n.div0 = 1'b0;
          end
        end
      end
      ST_RUN: begin
        dq_n  = step_dq;
        rem_n = step_rem;
        cnt_n = cnt - CW'(1);
        if (cnt == '0) begin
          state_n   = ST_DONE;
          res_n.quo = step_dq;
          res_n.rem = step_rem[VW-1:0];
        end
      end
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n == ST_RUN);
    done_n = (state_n == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      dq    <= '0;
      rem   <= '0;
      d     <= '0;
      res   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dq    <= dq_n;
      rem   <= rem_n;
      d     <= d_n;
      res   <= res_n;
      done  <= done_n;
      busy  <= busy_n;
    end
  end

  // sel only steers the view of the held result
  assign bus.uo_out  = sel ? {3'b000, res.div0, res.rem} : res.quo;
  assign bus.uio_out = {done, busy, 6'b00_0000};
  assign bus.uio_oe  = UIO_OE;
endmodule

// File: tb/tb_tt_um_seq_divider_structural.sv
// Directed bench for the sequential divider tile with a divide reference for the full sweep.
module tb_tt_um_seq_divider_structural;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] a_r = 8'd0;
  logic [3:0] d_r = 4'd0;
  logic       start_r = 1'b0;
  logic       sel_r = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         lat, bc;

  always #5 clk = ~clk;

  tt_um_seq_divider_structural_if bus ();

  assign bus.ui_in  = a_r;
  assign bus.uio_in = {2'b00, sel_r, start_r, d_r};

  tt_um_seq_divider_structural dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present operands and a one-cycle start pulse; returns #1 after the accepting edge
  task automatic start_div(input logic [7:0] a, input logic [3:0] b);
    @(negedge clk);
    a_r = a;
    d_r = b;
    start_r = 1'b1;
    @(posedge clk);
    #1;
    start_r = 1'b0;
  endtask

  task automatic wait_done(output int l, output int busy_cnt);
    l = 0;
    busy_cnt = 0;
    while (!bus.uio_out[7] && l < 20) begin
      if (bus.uio_out[6]) busy_cnt++;
      @(posedge clk);
      #1;
      l++;
    end
    if (!bus.uio_out[7]) check("done_timeout", 32'(bus.uio_out[7]), 32'd1);
  endtask

  task automatic check_res(input string tag, input logic [7:0] q, input logic [3:0] r,
                           input logic dz);
    sel_r = 1'b0;
    #1;
    check({tag, "_q"}, 32'(bus.uo_out), 32'(q));
    sel_r = 1'b1;
    #1;
    check({tag, "_r"}, 32'(bus.uo_out), 32'({3'b000, dz, r}));
    sel_r = 1'b0;
  endtask

  initial begin
    // reset values
    #12;
    check("rst_uo", 32'(bus.uo_out), 32'h00);
    check("rst_uio_out", 32'(bus.uio_out), 32'h00);
    check("rst_oe", 32'(bus.uio_oe), 32'hC0);
    @(negedge clk);
    rst_n = 1'b1;

    // 200 / 7 = 28 r 4
    start_div(8'd200, 4'd7);
    check("t1_busy0", 32'(bus.uio_out), 32'h40);
    wait_done(lat, bc);
    check("t1_lat", 32'(lat), 32'd8);
    check("t1_busycyc", 32'(bc), 32'd8);
    check("t1_flags", 32'(bus.uio_out), 32'h80);
    check_res("t1", 8'd28, 4'd4, 1'b0);

    // 255 / 1 and 5 / 9
    start_div(8'd255, 4'd1);
    wait_done(lat, bc);
    check_res("t2a", 8'hFF, 4'd0, 1'b0);
    start_div(8'd5, 4'd9);
    wait_done(lat, bc);
    check_res("t2b", 8'd0, 4'd5, 1'b0);

    // divide by zero
    start_div(8'd77, 4'd0);
    wait_done(lat, bc);
    check("t3_lat", 32'(lat), 32'd0);
    check("t3_busycyc", 32'(bc), 32'd0);
    check_res("t3", 8'hFF, 4'hF, 1'b1);

    // start during RUN ignored; operand changes after acceptance ignored
    start_div(8'd144, 4'd12);
    check("t4_div0clr", 32'(bus.uo_out), 32'hFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    a_r = 8'd10;
    d_r = 4'd3;
    start_r = 1'b1;
    @(posedge clk);
    #1;
    start_r = 1'b0;
    check("t4_busy", 32'(bus.uio_out), 32'h40);
    wait_done(lat, bc);
    check("t4_lat", 32'(lat), 32'd5);
    check_res("t4", 8'd12, 4'd0, 1'b0);

    // async reset mid-run
    start_div(8'd50, 4'd3);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_uio_out", 32'(bus.uio_out), 32'h00);
    check_res("t5_rst", 8'd0, 4'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    start_div(8'd9, 4'd2);
    wait_done(lat, bc);
    check_res("t5", 8'd4, 4'd1, 1'b0);

    // start held high: back-to-back runs
    @(negedge clk);
    a_r = 8'd100;
    d_r = 4'd10;
    start_r = 1'b1;
    @(posedge clk);
    #1;
    wait_done(lat, bc);
    check("t6_lat1", 32'(lat), 32'd8);
    check_res("t6a", 8'd10, 4'd0, 1'b0);
    @(posedge clk);
    #1;
    check("t6_rerun", 32'(bus.uio_out), 32'h40);
    wait_done(lat, bc);
    check_res("t6b", 8'd10, 4'd0, 1'b0);
    @(negedge clk);
    start_r = 1'b0;

    // exhaustive sweep against a reference divide
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [7:0] eq;
        logic [3:0] er;
        if (b == 0) begin
          eq = 8'hFF;
          er = 4'hF;
        end else begin
          eq = 8'(a / b);
          er = 4'(a % b);
        end
        start_div(8'(a), 4'(b));
        wait_done(lat, bc);
        check_res($sformatf("sw_%0d_%0d", a, b), eq, er, (b == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
